pipe_mem_stage: RTL
===================

// Module: pipe_mem_stage
// PURPOSE
//   MEM stage of the five-stage pipeline; consumes the EX/MEM register outputs (mwreg..mrn).
//   Drives a variable-latency data-memory request/ready bus and stalls upstream stages until the access completes.
//   Registers results into the MEM/WB boundary (w* outputs) for writeback.
// PARAMETERS
//   AW          32   data-memory byte-address width (low AW bits of malu)
//   TIMEOUT     16   max wait cycles per access before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//   clock       in   1   sole clock, rising edge
//   reset       in   1   synchronous, active-high
//   mwreg       in   1   EX/MEM: register-file write enable
//   mm2reg      in   1   EX/MEM: load (result from memory)
//   mwmem       in   1   EX/MEM: store
//   malu        in   32  EX/MEM: ALU result / effective address
//   mb          in   32  EX/MEM: store data
//   mrn         in   5   EX/MEM: destination register
//   dmem_req    out  1   memory request valid
//   dmem_we     out  1   request is a write
//   dmem_addr   out  AW  word-aligned byte address
//   dmem_wdata  out  32  write data
//   dmem_ready  in   1   memory completes current request this cycle
//   dmem_rdata  in   32  read data, valid when dmem_ready & ~dmem_we
//   mem_stall   out  1   hold PC, IF/ID, ID/EX, EX/MEM this cycle
//   mem_misalign out 1   one-cycle pulse: access with malu[1:0]!=0 dropped
//   mem_timeout out  1   one-cycle pulse: access aborted (0 when MEM_TIMEOUT_EN absent)
//   wwreg,wm2reg out 1   MEM/WB: write enable, load select
//   wmo         out  32  MEM/WB: load data
//   walu        out  32  MEM/WB: ALU result
//   wrn         out  5   MEM/WB: destination register
// BEHAVIOUR
//   memop = mm2reg|mwmem; aligned = (malu[1:0]==0). mm2reg&mwmem together: treated as store, wm2reg=0.
//   FSM: IDLE, WAIT. dmem_* driven combinationally: req = memop&aligned&~reset in IDLE, =1 in WAIT.
//   IDLE, no memop: no request, no stall; MEM/WB captures inputs next edge (1-cycle latency), wmo<=0.
//   IDLE, memop aligned, dmem_ready=1: zero-wait; capture, stay IDLE, mem_stall=0.
//   IDLE, memop aligned, dmem_ready=0: -> WAIT; mem_stall=1; MEM/WB captures bubble (wwreg=0).
//   WAIT: dmem_req/we/addr/wdata held from stalled EX/MEM; stall=~dmem_ready; on ready capture, wmo<=dmem_rdata (loads), -> IDLE.
//   Misaligned memop: no request, no stall; MEM/WB bubble (wwreg=0,wm2reg=0); mem_misalign=1 for that cycle.
//   dmem_ready outside an active request is ignored.
//   Reset: state=IDLE, wwreg=wm2reg=0, wmo=walu=0, wrn=0, pulses 0, wait counter 0; reset mid-WAIT abandons access, dmem_req=0 during reset cycle.
//   Bubble = wwreg=0,wm2reg=0; walu/wrn/wmo hold previous value.
// CONFIGURATION
//   MEM_TIMEOUT_EN defined: counter counts WAIT cycles; when count reaches TIMEOUT-1 with no ready,
//     drop req, -> IDLE, mem_timeout=1 one cycle, bubble to MEM/WB, stall released that cycle; ready on same cycle wins.
//   MEM_TIMEOUT_EN undefined: no counter; WAIT persists until dmem_ready; mem_timeout tied 0.
// STRUCTURE
//   Shared header pipe_defs.vh: state encodings (MS_IDLE, MS_WAIT), register-index width, bubble constants.
//   Sub-module pipe_mwreg: MEM/WB register (sync reset, load enable, bubble insert); FSM + bus logic in top.
// TESTING
//   ALU op malu=0x1234,mrn=3,mwreg=1 -> next edge walu=0x1234,wrn=3,wwreg=1, no req, no stall.
//   Load malu=0x40, ready same cycle, rdata=0xDEADBEEF -> wmo=0xDEADBEEF,wm2reg=1,stall never 1.
//   Store malu=0x80,mb=0x55, ready after 3 cycles -> req/we/addr/wdata stable 4 cycles, stall 3 cycles, then wwreg=0.
//   Load malu=0x42 -> no req, mem_misalign pulse, wwreg=0 next edge, no stall.
//   Reset asserted 2nd cycle of WAIT -> req=0 that cycle, state IDLE, all w* outputs 0.
//   MEM_TIMEOUT_EN,TIMEOUT=4, ready never -> stall 4 cycles, mem_timeout pulse, bubble, pipeline resumes.

Source files
------------

// File: rtl/pipe_mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
//   mem_state_e : MEM access FSM encodings (MS_IDLE, MS_WAIT)
//   mw_t        : MEM/WB boundary payload
//   BUBBLE_*    : control values written when a bubble enters MEM/WB
package pipe_mem_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RN_W = 5;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic [XLEN-1:0] mo;
        logic [XLEN-1:0] alu;
        logic [RN_W-1:0] rn;
    } mw_t;

    localparam logic BUBBLE_WREG  = 1'b0;
    localparam logic BUBBLE_M2REG = 1'b0;

endpackage

// File: rtl/pipe_mem_stage_mwreg.sv
// MEM/WB pipeline register with bubble insertion.
//   clock, reset : rising-edge clock, synchronous active-high reset (clears all fields)
//   en           : capture d this edge
//   bub          : when not capturing, clear the control bits; data fields hold
//   d, q         : MEM/WB payload in / registered out
module pipe_mem_stage_mwreg
    import pipe_mem_stage_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic bub,
    input  mw_t  d,
    output mw_t  q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else if (bub) begin
            q.wreg  <= BUBBLE_WREG;
            q.m2reg <= BUBBLE_M2REG;
        end
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: issues data-memory accesses from the EX/MEM register, stalls the
// upstream pipeline while the memory is busy and fills the MEM/WB register.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   mwreg..mrn              : EX/MEM register outputs
//   dmem_req/we/addr/wdata  : request bus (combinational)
//   dmem_ready, dmem_rdata  : memory completion and read data
//   mem_stall               : hold upstream stages (combinational)
//   mem_misalign            : pulse, misaligned access dropped
//   mem_timeout             : pulse, access aborted after TIMEOUT wait cycles
//   wwreg..wrn              : MEM/WB register outputs
// Build option: define MEM_TIMEOUT_EN to enable the wait-cycle abort counter.
module pipe_mem_stage
    import pipe_mem_stage_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic            mwmem,
    input  logic [XLEN-1:0] malu,
    input  logic [XLEN-1:0] mb,
    input  logic [RN_W-1:0] mrn,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [AW-1:0]   dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_stall,
    output logic            mem_misalign,
    output logic            mem_timeout,
    output logic            wwreg,
    output logic            wm2reg,
    output logic [XLEN-1:0] wmo,
    output logic [XLEN-1:0] walu,
    output logic [RN_W-1:0] wrn
);

    mem_state_e state_q, state_d;

    logic memop, aligned, is_load;
    logic req_c, stall_c, misalign_c, timeout_c, complete_c;
    mw_t  mw_d, mw_q;

    // A combined load+store is treated as a store.
    assign memop   = mm2reg | mwmem;
    assign aligned = (malu[1:0] == 2'b00);
    assign is_load = mm2reg & ~mwmem;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Counts cycles spent in WAIT for the current access.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bus request, stall and MEM/WB capture decision.
    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        timeout_c  = 1'b0;
        complete_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        if (!reset) begin
            case (state_q)
                MS_IDLE: begin
                    if (!memop) begin
                        complete_c = 1'b1;
                    end else if (!aligned) begin
                        misalign_c = 1'b1;
                    end else begin
                        req_c = 1'b1;
                        if (dmem_ready) begin
                            complete_c = 1'b1;
                        end else begin
                            stall_c = 1'b1;
                            state_d = MS_WAIT;
`ifdef MEM_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end
                end
                MS_WAIT: begin
                    req_c = 1'b1;
                    if (dmem_ready) begin
                        complete_c = 1'b1;
                        state_d    = MS_IDLE;
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        // Abort: drop the request and release the stall this cycle.
                        if (cnt_last) begin
                            req_c     = 1'b0;
                            timeout_c = 1'b1;
                            state_d   = MS_IDLE;
                        end else begin
                            stall_c = 1'b1;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
`else
                        stall_c = 1'b1;
`endif
                    end
                end
                default: state_d = MS_IDLE;
            endcase
        end
    end

    assign dmem_req     = req_c;
    assign dmem_we      = mwmem;
    assign dmem_addr    = AW'(malu) & ~AW'(3);
    assign dmem_wdata   = mb;
    assign mem_stall    = stall_c;
    assign mem_misalign = misalign_c;
    assign mem_timeout  = timeout_c;

    // Non-load results clear wmo so stale load data never reaches WB.
    always_comb begin
        mw_d.wreg  = mwreg;
        mw_d.m2reg = is_load;
        mw_d.mo    = is_load ? dmem_rdata : '0;
        mw_d.alu   = malu;
        mw_d.rn    = mrn;
    end

    pipe_mem_stage_mwreg u_mwreg (
        .clock (clock),
        .reset (reset),
        .en    (complete_c),
        .bub   (~complete_c),
        .d     (mw_d),
        .q     (mw_q)
    );

    assign wwreg  = mw_q.wreg;
    assign wm2reg = mw_q.m2reg;
    assign wmo    = mw_q.mo;
    assign walu   = mw_q.alu;
    assign wrn    = mw_q.rn;

endmodule
